// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: clears a fibonacci generator, paces its requests against a small FIFO
// and streams the captured terms out with tlast on the final one.
module fib_seq_ctrl #(
  parameter int SEQ_BITS = 32,
  parameter int CNT_BITS = 16,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CNT_BITS-1:0] cmd_count,
  output logic                gen_rst,
  output logic                gen_next,
  input  logic [SEQ_BITS-1:0] gen_seq,
  input  logic                gen_seq_valid,
  output logic [SEQ_BITS-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                busy,
  output logic                overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [CNT_BITS-1:0] count, issued, captured;
  logic [SEQ_BITS:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] occ;
  logic [SEQ_BITS-1:0] prev;
  logic inflight, cap, pop, accept;
  always_comb begin
    cmd_ready = ~rst & (state == IDLE);
    accept = cmd_ready & cmd_valid & (cmd_count != '0);
    busy = state != IDLE;
    gen_rst = rst | (state == CLEAR);
    // in-flight term is reserved a FIFO slot so the FIFO can never overflow
    gen_next = ~rst & (state == RUN) & (issued < count) & (occ + {{AW{1'b0}}, inflight} < FULL);
    cap = gen_seq_valid & inflight;
    m_tvalid = ~rst & (occ != '0);
    pop = m_tvalid & m_tready;
    {m_tlast, m_tdata} = m_tvalid ? mem[rptr] : '0;
    case (state)
      IDLE:    state_nx = accept ? CLEAR : IDLE;
      CLEAR:   state_nx = RUN;
      RUN:     state_nx = (issued == count && !inflight) ? DRAIN : RUN;
      DRAIN:   state_nx = (occ == '0) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      occ <= '0;
      wptr <= '0;
      rptr <= '0;
      inflight <= 1'b0;
      overflow <= 1'b0;
      count <= '0;
      issued <= '0;
      captured <= '0;
      prev <= '0;
    end else begin
      state <= state_nx;
      inflight <= gen_next | (inflight & ~gen_seq_valid);
      occ <= occ + (AW+1)'(cap) - (AW+1)'(pop);
      if (cap) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (accept) begin
        count <= cmd_count;
        overflow <= 1'b0;
      end
      if (state == CLEAR) begin
        issued <= '0;
        captured <= '0;
        prev <= '0;
      end else begin
        if (gen_next) issued <= issued + CNT_BITS'(1);
        if (cap) begin
          captured <= captured + CNT_BITS'(1);
          prev <= gen_seq;
          // a wrapped sum is always smaller than the term before it
          if (captured > CNT_BITS'(1) && gen_seq < prev) overflow <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) if (cap) mem[wptr] <= {captured == count - CNT_BITS'(1), gen_seq};
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: directed and randomized checks of fib_seq_ctrl against a
// fibonacci generator model and a mod-2^SB reference sequence.
module tb_fib_seq_ctrl;
  localparam int SB = 8, CB = 16, D = 4;
  logic clk = 0, rst = 1, cmd_valid = 0, m_tready = 1, gen_seq_valid = 0;
  logic [CB-1:0] cmd_count = '0;
  logic [SB-1:0] gen_seq = '0, ga = '0, gb = '0, m_tdata;
  logic cmd_ready, gen_rst, gen_next, m_tvalid, m_tlast, busy, overflow;
  int vectors = 0, miscompares = 0, cyc = 0, npulse = 0, stab_bad = 0, hs_cyc = 0;
  logic [SB:0] beats[$];
  int cap_cyc[$], tv_rise[$], ovf_rise[$];
  logic stall = 0, tv_q = 0, ov_q = 0;
  logic [SB:0] held = '0;

  fib_seq_ctrl #(.SEQ_BITS(SB), .CNT_BITS(CB), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
    .gen_rst(gen_rst), .gen_next(gen_next), .gen_seq(gen_seq), .gen_seq_valid(gen_seq_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  // generator: each request returns the current term one cycle later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    gen_seq_valid <= gen_next & ~gen_rst;
    if (gen_rst) begin
      ga <= '0;
      gb <= SB'(1);
    end else if (gen_next) begin
      gen_seq <= ga;
      ga <= gb;
      gb <= ga + gb;
    end
  end

  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (stall && {m_tvalid, m_tlast, m_tdata} !== {1'b1, held}) stab_bad++;
      if (m_tvalid && m_tready) beats.push_back({m_tlast, m_tdata});
      if (gen_next) npulse++;
      if (gen_seq_valid) cap_cyc.push_back(cyc);
      if (m_tvalid && !tv_q) tv_rise.push_back(cyc);
      if (overflow && !ov_q) ovf_rise.push_back(cyc);
    end
    stall = !rst && m_tvalid && !m_tready;
    held = {m_tlast, m_tdata};
    tv_q = m_tvalid;
    ov_q = overflow;
  end

  function automatic logic [SB-1:0] fib(input int i);
    longint a = 0, b = 1, t;
    for (int k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a[SB-1:0];
  endfunction

  function automatic logic wraps(input int n);
    logic w = 0;
    for (int i = 2; i < n; i++) if (fib(i) < fib(i-1)) w = 1;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input int n);
    int t = 0;
    cmd_count = CB'(n);
    cmd_valid = 1;
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", t < 500, 1);
    hs_cyc = cyc;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input bit rnd);
    int t = 0;
    if (!rnd) m_tready = 1;
    while (busy && t < 3000) begin
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    m_tready = 1;
    @(negedge clk);
    chk("idle_timeout", t < 3000, 1);
  endtask

  task automatic check_stream(input string tag, input int n, input int b0);
    for (int i = 0; i < n && b0 + i < beats.size(); i++)
      chk({tag, "_beat"}, beats[b0+i], {i == n - 1, fib(i)});
  endtask

  initial begin
    int b0, p0, r0, c0, t0, n;
    logic hi;
    repeat (2) @(negedge clk);
    chk("rst_gen_rst", gen_rst, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 0;
    @(negedge clk);
    chk("reset_state", {cmd_ready, gen_rst, gen_next, m_tvalid, m_tlast, m_tdata, busy, overflow}, {1'b1, 14'b0});

    b0 = beats.size(); t0 = tv_rise.size();
    accept(7);
    wait_idle(0);
    chk("basic_len", beats.size() - b0, 7);
    check_stream("basic", 7, b0);
    chk("basic_latency", tv_rise.size() > t0 ? tv_rise[t0] - hs_cyc : -1, 4);
    chk("basic_ovf", overflow, 0);

    b0 = beats.size(); p0 = npulse;
    m_tready = 0;
    accept(10);
    repeat (19) @(negedge clk);
    chk("bp_pulses", npulse - p0, D);
    chk("bp_no_beats", beats.size() - b0, 0);
    wait_idle(0);
    chk("bp_len", beats.size() - b0, 10);
    check_stream("bp", 10, b0);
    chk("bp_last", beats.size() >= b0 + 10 ? beats[b0+9] : '0, {1'b1, SB'(34)});

    b0 = beats.size(); p0 = npulse;
    accept(0);
    hi = 0;
    repeat (6) begin
      hi |= busy | gen_rst | gen_next | m_tvalid;
      @(negedge clk);
    end
    chk("zero_quiet", hi, 0);
    chk("zero_beats", beats.size() - b0 + npulse - p0, 0);

    b0 = beats.size(); c0 = cap_cyc.size(); r0 = ovf_rise.size();
    accept(16);
    wait_idle(0);
    chk("ovf_len", beats.size() - b0, 16);
    check_stream("ovf", 16, b0);
    chk("ovf_t13", beats.size() >= b0 + 16 ? beats[b0+13][SB-1:0] : '0, 233);
    chk("ovf_t14", beats.size() >= b0 + 16 ? beats[b0+14][SB-1:0] : '0, 121);
    chk("ovf_rises", ovf_rise.size() - r0, 1);
    chk("ovf_timing", (ovf_rise.size() > r0 && cap_cyc.size() > c0 + 14) ? ovf_rise[r0] - cap_cyc[c0+14] : -1, 1);
    chk("ovf_hold", overflow, 1);

    b0 = beats.size();
    cmd_count = 3;
    cmd_valid = 1;
    @(negedge clk);
    chk("ovf_clear", overflow, 0);
    cmd_count = 4;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", beats.size() - b0, 3);
    @(negedge clk);
    cmd_valid = 0;
    wait_idle(0);
    chk("b2b_len", beats.size() - b0, 7);
    check_stream("b2b_a", 3, b0);
    check_stream("b2b_b", 4, b0 + 3);

    accept(20);
    repeat (6) @(negedge clk);
    chk("mr_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    chk("mr_gen_rst", gen_rst, 1);
    rst = 0;
    #1;
    chk("mr_after", {busy, m_tvalid, cmd_ready}, 3'b001);
    b0 = beats.size();
    accept(2);
    wait_idle(0);
    chk("mr_len", beats.size() - b0, 2);
    check_stream("mr", 2, b0);

    repeat (6) begin
      n = $urandom_range(1, 30);
      b0 = beats.size();
      accept(n);
      wait_idle(1);
      chk("rnd_len", beats.size() - b0, n);
      check_stream("rnd", n, b0);
      chk("rnd_ovf", overflow, wraps(n));
    end

    chk("stable_while_stalled", stab_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
